// File: rtl/legv8_reg_file.sv
// ---------------------------------------------------------------------------
// legv8_reg_file
//
// Architectural register file for the pipelined LEGv8 core.
// X0..X30 are stored DATA_WIDTH-bit registers; X31 (XZR) has no storage
// and always reads as zero. Reads are combinational. A write presented in
// the same cycle is forwarded to the read ports, so an instruction in WB
// and a dependent instruction in ID need no stall.
//
// Ports:
//   clk         - single clock, all state updates on the rising edge
//   reset       - synchronous active-high reset; clears X0..X30 and
//                 suppresses both the write and the write-through bypass
//   read_reg1   - read port 1 address (Rn)
//   read_reg2   - read port 2 address (Reg2Loc mux output)
//   write_reg   - write address from MEM/WB
//   write_data  - write data from the WB mux
//   reg_write   - write enable from MEM/WB control
//   read_data1  - read port 1 data
//   read_data2  - read port 2 data
// ---------------------------------------------------------------------------
module legv8_reg_file #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  // The highest address is the zero register and owns no storage.
  localparam int unsigned NUM_STORED = (1 << ADDR_WIDTH) - 1;
  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '1;

  logic [DATA_WIDTH-1:0] regs_q [NUM_STORED];

  // Write accepted at the coming edge (ignoring reset, which is handled
  // separately in the state update).
  logic wr_en_d;
  // Write-through is allowed only when the write will actually commit.
  logic bypass_en;

  always_comb begin
    wr_en_d   = reg_write && (write_reg != ZERO_REG);
    bypass_en = wr_en_d && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_STORED; i++) begin
        regs_q[i[ADDR_WIDTH-1:0]] <= '0;
      end
    end else if (wr_en_d) begin
      regs_q[write_reg] <= write_data;
    end
  end

  // Each port: zero register first, then bypass, then storage. The zero
  // register check guards the storage index, so address 31 never selects
  // a nonexistent entry.
  always_comb begin
    read_data1 = '0;
    if (read_reg1 != ZERO_REG) begin
      if (bypass_en && (write_reg == read_reg1)) begin
        read_data1 = write_data;
      end else begin
        read_data1 = regs_q[read_reg1];
      end
    end
  end

  always_comb begin
    read_data2 = '0;
    if (read_reg2 != ZERO_REG) begin
      if (bypass_en && (write_reg == read_reg2)) begin
        read_data2 = write_data;
      end else begin
        read_data2 = regs_q[read_reg2];
      end
    end
  end

endmodule

// File: tb/tb_legv8_reg_file.sv
module tb_legv8_reg_file;

  logic        clk;
  logic        reset;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [63:0] write_data;
  logic        reg_write;
  logic [63:0] read_data1;
  logic [63:0] read_data2;

  legv8_reg_file #(
    .DATA_WIDTH(64),
    .ADDR_WIDTH(5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .write_reg (write_reg),
    .write_data(write_data),
    .reg_write (reg_write),
    .read_data1(read_data1),
    .read_data2(read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference: architectural contents of X0..X30.
  logic [63:0] model [31];

  // Outputs sampled during the most recent cycle.
  logic [63:0] rd1_s;
  logic [63:0] rd2_s;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural read value for the inputs presented this cycle.
  function automatic logic [63:0] exp_read(input logic r, input logic w,
                                           input logic [4:0] wa, input logic [63:0] wd,
                                           input logic [4:0] a);
    if (a == 5'd31) return 64'd0;
    if (w && !r && wa == a) return wd;
    return model[a];
  endfunction

  // Present inputs (called just after a falling edge), check both read
  // ports mid-cycle, then take the rising edge and update the model.
  task automatic do_cycle(input logic r, input logic w, input logic [4:0] wa,
                          input logic [63:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    reset = r; reg_write = w; write_reg = wa; write_data = wd;
    read_reg1 = a1; read_reg2 = a2;
    #1;
    rd1_s = read_data1;
    rd2_s = read_data2;
    check($sformatf("rd1[a=%0d]", a1), rd1_s, exp_read(r, w, wa, wd, a1));
    check($sformatf("rd2[a=%0d]", a2), rd2_s, exp_read(r, w, wa, wd, a2));
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 31; i++) model[i] = 64'd0;
    end else if (w && wa != 5'd31) begin
      model[wa] = wd;
    end
    @(negedge clk);
  endtask

  // Read every address on both ports without writing; all must be zero.
  task automatic zero_sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      do_cycle(1'b0, 1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i));
      check({tag, "_p1"}, rd1_s, 64'd0);
      check({tag, "_p2"}, rd2_s, 64'd0);
    end
  endtask

  // Read every address on both ports against the model.
  task automatic model_sweep();
    for (int i = 0; i < 32; i++) begin
      do_cycle(1'b0, 1'b0, 5'd0, 64'd0, 5'(i), 5'(i));
    end
  endtask

  initial begin
    reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = '0; read_reg2 = '0;
    // First reset edge: contents are undefined beforehand, so nothing is checked.
    @(posedge clk);
    for (int i = 0; i < 31; i++) model[i] = 64'd0;
    @(negedge clk);
    reset = 1'b0;

    zero_sweep("reset_init");

    // Write then read X5 on both ports.
    do_cycle(1'b0, 1'b1, 5'd5, 64'h0123_4567_89AB_CDEF, 5'd0, 5'd0);
    do_cycle(1'b0, 1'b0, 5'd0, 64'd0, 5'd5, 5'd5);
    check("wr_x5_p1", rd1_s, 64'h0123_4567_89AB_CDEF);
    check("wr_x5_p2", rd2_s, 64'h0123_4567_89AB_CDEF);

    // Bypass on port 2, then value from storage.
    do_cycle(1'b0, 1'b1, 5'd9, 64'hDEAD_BEEF_0000_0001, 5'd0, 5'd9);
    check("bypass_x9", rd2_s, 64'hDEAD_BEEF_0000_0001);
    do_cycle(1'b0, 1'b0, 5'd0, 64'd0, 5'd9, 5'd9);
    check("stored_x9", rd1_s, 64'hDEAD_BEEF_0000_0001);

    // XZR: write ignored, reads zero in same and next cycle, nothing else moves.
    do_cycle(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31);
    check("xzr_same", rd1_s, 64'd0);
    do_cycle(1'b0, 1'b0, 5'd0, 64'd0, 5'd31, 5'd5);
    check("xzr_next", rd1_s, 64'd0);
    check("xzr_x5_kept", rd2_s, 64'h0123_4567_89AB_CDEF);
    model_sweep();

    // Reset priority over a concurrent write; bypass disabled under reset.
    do_cycle(1'b0, 1'b1, 5'd3, 64'h77, 5'd0, 5'd0);
    do_cycle(1'b1, 1'b1, 5'd3, 64'h55, 5'd3, 5'd3);
    check("rstpri_during", rd1_s, 64'h77);
    do_cycle(1'b0, 1'b0, 5'd0, 64'd0, 5'd3, 5'd3);
    check("rstpri_after", rd1_s, 64'd0);

    // Independent ports: write X2 while reading X1 and X2.
    do_cycle(1'b0, 1'b1, 5'd1, 64'h11, 5'd0, 5'd0);
    do_cycle(1'b0, 1'b1, 5'd2, 64'h22, 5'd0, 5'd0);
    do_cycle(1'b0, 1'b1, 5'd2, 64'h99, 5'd1, 5'd2);
    check("indep_x1", rd1_s, 64'h11);
    check("indep_x2_byp", rd2_s, 64'h99);
    do_cycle(1'b0, 1'b0, 5'd0, 64'd0, 5'd1, 5'd2);
    check("indep_x1_after", rd1_s, 64'h11);
    check("indep_x2_after", rd2_s, 64'h99);

    // Back-to-back writes to one register with reads in between.
    do_cycle(1'b0, 1'b1, 5'd7, 64'hA1, 5'd7, 5'd7);
    do_cycle(1'b0, 1'b1, 5'd7, 64'hA2, 5'd7, 5'd6);
    check("b2b_byp", rd1_s, 64'hA2);
    do_cycle(1'b0, 1'b0, 5'd0, 64'd0, 5'd7, 5'd7);
    check("b2b_final", rd2_s, 64'hA2);

    // Randomized traffic, reads biased toward the write address.
    for (int n = 0; n < 600; n++) begin
      logic        r, w;
      logic [4:0]  wa, a1, a2;
      logic [63:0] wd;
      r  = ($urandom_range(0, 39) == 0);
      w  = ($urandom_range(0, 3) != 0);
      wa = 5'($urandom_range(0, 31));
      wd = {$urandom, $urandom};
      a1 = ($urandom_range(0, 1) == 1) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 1) == 1) ? wa : 5'($urandom_range(0, 31));
      do_cycle(r, w, wa, wd, a1, a2);
    end
    model_sweep();

    // Random writes, one reset edge, then everything reads zero.
    for (int n = 0; n < 20; n++) begin
      do_cycle(1'b0, 1'b1, 5'($urandom_range(0, 30)), {$urandom, $urandom}, 5'd0, 5'd0);
    end
    do_cycle(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    zero_sweep("reset_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
